counter_ctrl_unit: RTL and testbench



---
 rtl/counter_ctrl_pkg.sv | 16 +
 rtl/counter_ctrl_unit_tick_gen.sv | 41 ++++
 rtl/counter_ctrl_unit.sv | 82 ++++++++
 tb/tb_counter_ctrl_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared types and defaults for the counter control stage.
//   state_t        - FSM encoding (2'b11 is illegal and unused)
//   SYS_CLK_HZ_DEF - default system clock frequency
//   TICK_HZ_DEF    - default count-enable tick rate
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'b00,
    RUN   = 2'b01,
    CLEAR = 2'b10
  } state_t;

  localparam int SYS_CLK_HZ_DEF = 100_000_000;
  localparam int TICK_HZ_DEF    = 10;

endpackage

// File: rtl/counter_ctrl_unit_tick_gen.sv
// tick_gen: count-enable divider. Counts enabled cycles modulo TICK_DIV and
// emits a registered one-cycle pulse after the enabled cycle at TICK_DIV-1.
//   clk, rst - clock, async active-low reset
//   i_en     - advance the divider this cycle
//   i_clr    - force the divider to 0 (never coincides with i_en)
//   o_tick   - one-cycle count-enable pulse
// TICK_DIV must be at least 2 so the pulse can never repeat back-to-back.
module tick_gen #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == LAST);

  // Without i_en the count simply holds, which keeps the phase across a
  // stop/resume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= i_en & at_last;
      if (i_clr)
        cnt <= '0;
      else if (i_en)
        cnt <= at_last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/counter_ctrl_unit.sv
// counter_ctrl_unit: STOP/RUN/CLEAR control for the 0-9999 counter.
// Consumes debounced one-cycle button pulses and drives the datapath.
//   clk, rst    - clock, async active-low reset
//   i_btn_run   - toggles run/stop
//   i_btn_clear - clear request (honoured only from STOP)
//   i_btn_mode  - toggles up/down (honoured only from STOP)
//   o_run       - registered decode of RUN
//   o_clear     - registered decode of CLEAR, one cycle per clear
//   o_mode      - 0 = count up, 1 = count down
//   o_tick      - one-cycle count-enable pulse
//   o_state     - raw state register for debug/LEDs
module counter_ctrl_unit
  import counter_ctrl_pkg::*;
#(
  parameter int SYS_CLK_HZ = SYS_CLK_HZ_DEF,
  parameter int TICK_HZ    = TICK_HZ_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_mode,
  output logic       o_run,
  output logic       o_clear,
  output logic       o_mode,
  output logic       o_tick,
  output logic [1:0] o_state
);

  localparam int TICK_DIV = SYS_CLK_HZ / TICK_HZ;

  // Kept as a plain vector so the unused 2'b11 code is representable and
  // can be recovered from.
  logic [1:0] state_q;
  state_t     state_d;
  logic       in_run;
  logic       in_clear;

  assign in_run   = (state_q == RUN);
  assign in_clear = (state_q == CLEAR);
  assign o_state  = state_q;

  always_comb begin
    state_d = STOP;
    case (state_q)
      STOP: begin
        // clear beats run when both land in the same cycle
        if (i_btn_clear)    state_d = CLEAR;
        else if (i_btn_run) state_d = RUN;
        else                state_d = STOP;
      end
      RUN:     state_d = i_btn_run ? STOP : RUN;
      CLEAR:   state_d = STOP;
      default: state_d = STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= STOP;
      o_run   <= 1'b0;
      o_clear <= 1'b0;
      o_mode  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_run   <= in_run;
      o_clear <= in_clear;
      // mode toggle still applies alongside a run/clear pulse from STOP
      if ((state_q == STOP) && i_btn_mode)
        o_mode <= ~o_mode;
    end
  end

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (in_run),
    .i_clr  (in_clear),
    .o_tick (o_tick)
  );

endmodule

// File: tb/tb_counter_ctrl_unit.sv
// tb_counter_ctrl_unit: scoreboard bench. Each driven cycle updates a
// behavioural model and queues the outputs expected after the next edge;
// a monitor pops and compares them just after that edge.
module tb_counter_ctrl_unit;

  localparam int DIV = 10;

  logic       clk, rst, btn_run, btn_clear, btn_mode;
  logic       o_run, o_clear, o_mode, o_tick;
  logic [1:0] o_state;

  typedef struct {
    logic [1:0] st;
    logic       run, clr, mode, tick;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // behavioural model
  int   m_st  = 0;
  int   m_div = 0;
  logic m_run = 0, m_clr = 0, m_mode = 0, m_tick = 0;
  logic prev_tick = 0;

  counter_ctrl_unit #(.SYS_CLK_HZ(100), .TICK_HZ(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_btn_run   (btn_run),
    .i_btn_clear (btn_clear),
    .i_btn_mode  (btn_mode),
    .o_run       (o_run),
    .o_clear     (o_clear),
    .o_mode      (o_mode),
    .o_tick      (o_tick),
    .o_state     (o_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Drive one cycle of button inputs, advance the model across the coming
  // edge, queue the expected outputs and return at the following negedge.
  task automatic cyc(input logic r, input logic c, input logic m);
    exp_t e;
    logic n_run, n_clr, n_tick;
    btn_run   = r;
    btn_clear = c;
    btn_mode  = m;
    if (!rst) begin
      m_st = 0; m_div = 0;
      m_run = 0; m_clr = 0; m_mode = 0; m_tick = 0;
    end else begin
      n_run  = (m_st == 1);
      n_clr  = (m_st == 2);
      n_tick = (m_st == 1) && (m_div == DIV - 1);
      if (m_st == 0 && m) m_mode = !m_mode;
      if (m_st == 2)      m_div = 0;
      else if (m_st == 1) m_div = (m_div + 1) % DIV;
      case (m_st)
        0:       m_st = c ? 2 : (r ? 1 : 0);
        1:       m_st = r ? 0 : 1;
        default: m_st = 0;
      endcase
      m_run = n_run; m_clr = n_clr; m_tick = n_tick;
    end
    e.st = 2'(m_st); e.run = m_run; e.clr = m_clr; e.mode = m_mode; e.tick = m_tick;
    exp_q.push_back(e);
    @(negedge clk);
    btn_run = 1'b0; btn_clear = 1'b0; btn_mode = 1'b0;
  endtask

  // Count cycles until o_tick is seen; optionally pulse clear+mode in RUN.
  task automatic wait_tick(input bit noise, output int n);
    n = 0;
    while (o_tick !== 1'b1 && n < 40) begin
      cyc(1'b0, noise && (n % 3 == 1), noise && (n % 3 == 1));
      n++;
    end
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state", o_state, e.st);
      chk("run",   o_run,   e.run);
      chk("clear", o_clear, e.clr);
      chk("mode",  o_mode,  e.mode);
      chk("tick",  o_tick,  e.tick);
    end
    chk("tick_dbl", o_tick & prev_tick, 0);
    prev_tick = o_tick;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ticks;
    rst = 1'b0; btn_run = 1'b0; btn_clear = 1'b0; btn_mode = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst = 1'b1;
    cyc(0, 0, 0);

    // run, 35 RUN cycles, stop
    cyc(1, 0, 0);
    ticks = 0;
    for (int i = 0; i < 35; i++) begin
      cyc(0, 0, 0);
      if (o_tick) ticks++;
    end
    chk("tick_cnt", ticks, 3);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("run_off", o_run, 0);

    // clear and run together from STOP: clear wins; buttons ignored in CLEAR
    cyc(1, 1, 0);
    cyc(1, 1, 1);
    chk("clr_hi", o_clear, 1);
    cyc(0, 0, 0);
    chk("clr_lo", o_clear, 0);
    chk("run_stay", o_run, 0);
    chk("mode_keep", o_mode, 0);
    cyc(1, 0, 0);
    wait_tick(0, n);
    chk("first_tick_clr", n, 10);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);

    // pause with divider at 4, idle, resume
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (50) cyc(0, 0, 0);
    cyc(1, 0, 0);
    wait_tick(0, n);
    chk("resume_tick", n, 6);
    cyc(1, 0, 0);

    // mode in STOP toggles; mode/clear in RUN ignored
    cyc(0, 0, 1);
    chk("mode_set", o_mode, 1);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    wait_tick(1, n);
    chk("tick_noise", n, 10);
    chk("mode_hold", o_mode, 1);
    chk("noise_no_clr", o_clear, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    chk("mode_w_run", o_mode, 0);

    // async reset mid-RUN with divider at 7
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 1);
    repeat (7) cyc(0, 0, 0);
    chk("run_pre_rst", o_run, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_run",   o_run,   0);
    chk("rst_clear", o_clear, 0);
    chk("rst_mode",  o_mode,  0);
    chk("rst_tick",  o_tick,  0);
    chk("rst_state", o_state, 0);
    cyc(0, 0, 0);
    rst = 1'b1;
    cyc(1, 0, 0);
    wait_tick(0, n);
    chk("tick_after_rst", n, 10);
    cyc(1, 0, 0);
    cyc(0, 0, 0);

    // illegal state recovers to STOP
    force dut.state_q = 2'b11;
    m_st = 3;
    #1;
    chk("ill_forced", o_state, 3);
    release dut.state_q;
    cyc(0, 0, 0);
    chk("ill_state", o_state, 0);
    cyc(0, 0, 0);
    chk("ill_clr",  o_clear, 0);
    chk("ill_tick", o_tick,  0);
    chk("ill_run",  o_run,   0);

    repeat (2) cyc(0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
